// File: rtl/dds_pkg.sv
// Shared DDS definitions: wave-select codes, DAC midscale, default widths.
// Used by the control stage and dds_wave_gen (feature macro PHASE_RESET_ON_SEL_EN).
package dds_pkg;

   localparam int ACC_W_DEF  = 32;
   localparam int ROM_AW_DEF = 10;
   localparam int DAC_W_DEF  = 8;
   localparam int FREQ_W     = 20;
   localparam int PROD_W     = 28;

   localparam logic [7:0] FREQ_MULT_DEF = 8'd86;
   localparam logic [7:0] DAC_MID       = 8'd128;

   localparam real DDS_PI = 3.141592653589793;

   typedef enum logic [1:0] {
      SEL_SIN    = 2'b00,
      SEL_SQUARE = 2'b01,
      SEL_TRI    = 2'b10,
      SEL_SAW    = 2'b11
   } wave_sel_e;

   typedef struct packed {
      wave_sel_e  sel;
      logic [1:0] a;
   } wave_ctl_t;

   // round(mid + mid*sin(2*pi*i/2^aw)), mid = (2^dw-1)/2
   function automatic int sin_entry(int i, int aw, int dw);
      real amp;
      amp = real'((1 << dw) - 1) / 2.0;
      return $rtoi(amp + amp * $sin(2.0 * DDS_PI * real'(i) / real'(1 << aw)) + 0.5);
   endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// Synchronous sine ROM, one cycle read latency.
// Contents are elaborated from the rounded-sine formula in dds_pkg.
module dds_sin_rom
   import dds_pkg::*;
#(
   parameter int AW = ROM_AW_DEF,
   parameter int DW = DAC_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   logic [DW-1:0] rom [2**AW];
   logic [DW-1:0] data_d;
   logic [DW-1:0] data_q;

   for (genvar i = 0; i < 2**AW; i++) begin : g_rom
      assign rom[i] = DW'(sin_entry(i, AW, DW));
   end

   always_comb begin
      data_d = rom[addr];
   end

   // Reset value equals rom[0], the sample for phase 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= DW'(DAC_MID);
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, sine/square/tri/saw, attenuator.
// Optional PHASE_RESET_ON_SEL_EN restarts phase at 0 on a waveform change.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter logic [7:0] FREQ_MULT = FREQ_MULT_DEF,
   parameter int         ACC_W     = ACC_W_DEF,
   parameter int         ROM_AW    = ROM_AW_DEF,
   parameter int         DAC_W     = DAC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        wave_sel,
   input  logic [FREQ_W-1:0] wave_freq,
   input  logic [1:0]        wave_a,
   output logic [DAC_W-1:0]  dac_data,
   output logic              dac_valid
);

   logic [ACC_W-1:0]  ftw_d;
   logic [ACC_W-1:0]  ftw_q;
   logic [ACC_W-1:0]  phase_acc_d;
   logic [ACC_W-1:0]  phase_acc_q;
   wave_ctl_t         ctl1_d;
   wave_ctl_t         ctl1_q;
   wave_ctl_t         ctl2_d;
   wave_ctl_t         ctl2_q;
   logic [DAC_W-1:0]  raw_d;
   logic [DAC_W-1:0]  raw_q;
   logic [DAC_W-1:0]  dac_d;
   logic [DAC_W-1:0]  dac_q;
   logic [1:0]        vcnt_d;
   logic [1:0]        vcnt_q;
   logic              valid_d;
   logic              valid_q;

   logic [PROD_W-1:0] prod;
   logic              sel_chg;
   logic [DAC_W-1:0]  p;
   logic [ROM_AW-1:0] addr;
   logic [DAC_W-1:0]  rom_data;
   logic [DAC_W-1:0]  raw_sel;
   logic signed [DAC_W:0] s;
   logic signed [DAC_W:0] s_sh;

   dds_sin_rom #(
      .AW (ROM_AW),
      .DW (DAC_W)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .data  (rom_data)
   );

   always_comb begin
      prod  = PROD_W'(wave_freq) * PROD_W'(FREQ_MULT);
      ftw_d = ACC_W'(prod);
`ifdef PHASE_RESET_ON_SEL_EN
      sel_chg = (wave_sel != ctl1_q.sel);
`else
      sel_chg = 1'b0;
`endif
      phase_acc_d = sel_chg ? '0 : phase_acc_q + ftw_q;
      ctl1_d      = '{sel: wave_sel_e'(wave_sel), a: wave_a};
      ctl2_d      = ctl1_q;
   end

   always_comb begin
      p     = phase_acc_q[ACC_W-1 -: DAC_W];
      addr  = phase_acc_q[ACC_W-1 -: ROM_AW];
      raw_d = '0;
      // Sine comes straight from the registered ROM, so raw_q idles for it.
      unique case (1'b1)
         ctl1_q.sel == SEL_SQUARE: raw_d = p[DAC_W-1] ? '0 : '1;
         ctl1_q.sel == SEL_TRI:
            raw_d = p[DAC_W-1] ? ~{p[DAC_W-2:0], 1'b0}
                               :  {p[DAC_W-2:0], 1'b0};
         ctl1_q.sel == SEL_SAW:    raw_d = p;
         default:                  raw_d = '0;
      endcase
   end

   always_comb begin
      raw_sel = (ctl2_q.sel == SEL_SIN) ? rom_data : raw_q;
      s       = $signed({1'b0, raw_sel}) - $signed({1'b0, DAC_MID});
      s_sh    = s >>> ctl2_q.a;
      dac_d   = DAC_W'(s_sh + $signed({1'b0, DAC_MID}));
   end

   always_comb begin
      vcnt_d  = (vcnt_q == 2'd3) ? vcnt_q : vcnt_q + 2'd1;
      valid_d = valid_q | (vcnt_q == 2'd2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ftw_q       <= '0;
         phase_acc_q <= '0;
         ctl1_q      <= '{sel: SEL_SIN, a: 2'd0};
         ctl2_q      <= '{sel: SEL_SIN, a: 2'd0};
         raw_q       <= '0;
         dac_q       <= DAC_W'(DAC_MID);
         vcnt_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         ftw_q       <= ftw_d;
         phase_acc_q <= phase_acc_d;
         ctl1_q      <= ctl1_d;
         ctl2_q      <= ctl2_d;
         raw_q       <= raw_d;
         dac_q       <= dac_d;
         vcnt_q      <= vcnt_d;
         valid_q     <= valid_d;
      end
   end

   assign dac_data  = dac_q;
   assign dac_valid = valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: cycle model scoreboard plus
// table-driven level windows and hand-written timing sequences.
module tb_dds_wave_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  wave_sel;
   logic [19:0] wave_freq;
   logic [1:0]  wave_a;
   logic [7:0]  dac_data;
   logic        dac_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dds_wave_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wave_sel  (wave_sel),
      .wave_freq (wave_freq),
      .wave_a    (wave_a),
      .dac_data  (dac_data),
      .dac_valid (dac_valid)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int sine_ref(int i);
      real x;
      x = 127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * real'(i) / 1024.0);
      return $rtoi(x + 0.5);
   endfunction

   function automatic int shape(logic [1:0] sel, logic [31:0] ph);
      int p;
      p = int'(ph[31:24]);
      case (sel)
         2'd0:    return sine_ref(int'(ph[31:22]));
         2'd1:    return (p < 128) ? 255 : 0;
         2'd2:    return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         default: return p;
      endcase
   endfunction

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic [31:0] ph;
   } exp_t;

   exp_t sb[$];

   // Reference pipeline: state as seen before each edge
   logic [31:0] m_ftw, m_ph;
   logic [1:0]  m_s1, m_a1, m_a2;
   int          m_raw, m_cnt;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_ftw = 0; m_ph = 0; m_s1 = 0; m_a1 = 0; m_a2 = 0;
            m_raw = 128; m_cnt = 0;
            sb.push_back('{1'b0, 8'd128, 32'd0});
         end else begin
            int nd;
            logic [31:0] nph;
            nd  = ((m_raw - 128) >>> m_a2) + 128;
            nph = m_ph + m_ftw;
`ifdef PHASE_RESET_ON_SEL_EN
            if (wave_sel != m_s1) nph = 0;
`endif
            m_raw = shape(m_s1, m_ph);
            m_a2  = m_a1;
            m_ph  = nph;
            m_s1  = wave_sel;
            m_a1  = wave_a;
            m_ftw = 32'(wave_freq) * 32'd86;
            if (m_cnt < 3) m_cnt++;
            sb.push_back('{(m_cnt == 3), nd[7:0], nph});
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cyc_dac", dac_data, e.d);
            chk("cyc_valid", dac_valid, e.v);
            chk("cyc_phase", dut.phase_acc_q, e.ph);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]  sel;
      logic [1:0]  a;
      logic [19:0] freq;
      int          cyc;
      int          hi;
      int          lo;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int prev, decs, nw, w0, w1, hi, lo, refd, wr;
      logic [31:0] ph0;

      tbl[0] = '{2'd1, 2'd0, 20'd5000,  10100, 255, 0};
      tbl[1] = '{2'd1, 2'd1, 20'd50000,  1100, 191, 64};
      tbl[2] = '{2'd1, 2'd3, 20'd50000,  1100, 143, 112};
      tbl[3] = '{2'd2, 2'd0, 20'd50000,  1100, 255, 0};
      tbl[4] = '{2'd2, 2'd2, 20'd50000,  1100, 159, 96};
      tbl[5] = '{2'd0, 2'd0, 20'd10000,  5100, 255, 0};
      tbl[6] = '{2'd1, 2'd2, 20'd50000,  1100, 159, 96};

      rst_n     = 1'b0;
      wave_sel  = 2'($urandom);
      wave_a    = 2'($urandom);
      wave_freq = 20'($urandom);
      repeat (5) @(negedge clk);
      chk("rst_dac", dac_data, 128);
      chk("rst_valid", dac_valid, 0);

      rst_n = 1'b1; wave_sel = 2'd3; wave_a = 2'd0; wave_freq = 20'd500;
      @(negedge clk);
      chk("valid_e1", dac_valid, 0);
      chk("ftw_500", dut.ftw_q, 43000);
      @(negedge clk);
      chk("valid_e2", dac_valid, 0);
      chk("phase_e2", dut.phase_acc_q, 43000);
      @(negedge clk);
      chk("valid_e3", dac_valid, 1);
      chk("phase_e3", dut.phase_acc_q, 86000);

      prev = dac_data; decs = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (dac_data < prev) decs++;
         prev = dac_data;
      end
      chk("saw_mono", decs, 0);
      chk("saw_moved", dac_data > 0, 1);

      wave_freq = 20'd50000;
      repeat (4) @(negedge clk);
      prev = dac_data; nw = 0; w0 = 0; w1 = 0;
      for (int i = 0; i < 2600; i++) begin
         @(negedge clk);
         if (dac_data + 100 < prev) begin
            if (nw == 0) w0 = i;
            if (nw == 1) w1 = i;
            nw++;
         end
         prev = dac_data;
      end
      chk("saw_wrap_seen", nw >= 2, 1);
      chk("saw_wrap_period", (w1 - w0 >= 998) && (w1 - w0 <= 1000), 1);

      for (int k = 0; k < 7; k++) begin
         wave_sel = tbl[k].sel; wave_a = tbl[k].a; wave_freq = tbl[k].freq;
         repeat (6) @(negedge clk);
         hi = 0; lo = 255;
         for (int i = 0; i < tbl[k].cyc; i++) begin
            @(negedge clk);
            if (dac_data > hi) hi = dac_data;
            if (dac_data < lo) lo = dac_data;
         end
         chk($sformatf("tbl%0d_hi", k), hi, tbl[k].hi);
         chk($sformatf("tbl%0d_lo", k), lo, tbl[k].lo);
      end

      wave_sel = 2'd3; wave_a = 2'd0; wave_freq = 20'hFFFFF;
      repeat (2) @(negedge clk);
      chk("ftw_max", dut.ftw_q, 90177450);
      prev = int'(dut.phase_acc_q[31:24]); wr = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (int'(dut.phase_acc_q[31:24]) < prev) wr++;
         prev = int'(dut.phase_acc_q[31:24]);
      end
      chk("max_wraps", wr >= 2, 1);

      wave_freq = 20'd0;
      repeat (4) @(negedge clk);
      refd = dac_data; ph0 = dut.phase_acc_q;
      repeat (20) @(negedge clk);
      chk("f0_dac", dac_data, refd);
      chk("f0_phase", dut.phase_acc_q, ph0);

      wave_sel = 2'd3; wave_freq = 20'd50000;
      repeat (10) @(negedge clk);
      ph0 = dut.phase_acc_q;
      wave_sel = 2'd0;
      @(negedge clk);
`ifdef PHASE_RESET_ON_SEL_EN
      chk("sel_phase0", dut.phase_acc_q, 0);
      repeat (2) @(negedge clk);
      chk("sel_sin_first", dac_data, 128);
      wave_sel = 2'd3;
      @(negedge clk);
      chk("sel_phase0b", dut.phase_acc_q, 0);
      repeat (2) @(negedge clk);
      chk("sel_saw_first", dac_data, 0);
`else
      chk("sel_phase_cont", dut.phase_acc_q, ph0 + 32'd4300000);
`endif

      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_dac", dac_data, 128);
      chk("mid_rst_valid", dac_valid, 0);
      chk("mid_rst_phase", dut.phase_acc_q, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rel_e2", dac_valid, 0);
      @(negedge clk);
      chk("mid_rel_e3", dac_valid, 1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
